// File: rtl/nios2_oci_dct_sequencer_if.sv
// Output slot between the DCT sequencer and trace memory.
// master: drives out_valid/out_data, samples out_ready; slave: the reverse.
interface nios2_oci_dct_sequencer_if;
   logic        out_valid;
   logic        out_ready;
   logic [35:0] out_data;

   modport master (
      output out_valid,
      output out_data,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      output out_ready
   );
endinterface

// File: rtl/nios2_oci_dct_sequencer.sv
// Nios II OCI DCT sequencer: packs 2-bit trace atoms into a 30-bit buffer
// and closes it on full, flush, idle timeout or trace disable.
// Ports: clk, reset (async, active-high), trace_enable, atom_valid,
//   atom_data[1:0], flush_req, out (master slot: out_valid/out_ready/
//   out_data[35:0] = {count, tag, buffer}), dct_buffer[29:0],
//   dct_count[3:0], stall, drop_count[7:0], flush_done.
module nios2_oci_dct_sequencer #(
   parameter int unsigned FLUSH_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        trace_enable,
   input  logic        atom_valid,
   input  logic [1:0]  atom_data,
   input  logic        flush_req,
   nios2_oci_dct_sequencer_if.master out,
   output logic [29:0] dct_buffer,
   output logic [3:0]  dct_count,
   output logic        stall,
   output logic [7:0]  drop_count,
   output logic        flush_done
);

   typedef enum logic {FILL, HOLD} state_t;

   localparam logic [7:0] TMO = 8'(FLUSH_TIMEOUT);

   state_t      state_q, state_d;
   logic [29:0] buf_q, buf_d, buf_acc, wbuf;
   logic [3:0]  cnt_q, cnt_d, wcnt;
   logic [1:0]  tag_q, tag_d, tag;
   logic [7:0]  tmo_q, tmo_d, tmo_inc;
   logic        ov_q, ov_d;
   logic [35:0] od_q, od_d;
   logic [7:0]  drop_q, drop_d, drop_sat;
   logic        fd_q, fd_d;
   logic        stall_q;
   logic        en_q;
   logic        fpend_q, fpend_d;

   logic slot_free, take, arrive, acc, cnt_nz;
   logic full, flush_ev, tmo_ev, dis_ev, close;

   always_comb begin
      slot_free = !ov_q || out.out_ready;
      take      = ov_q && out.out_ready;
      arrive    = trace_enable && atom_valid;
      acc       = (state_q == FILL) && arrive;
      cnt_nz    = (cnt_q != 4'd0);
      tmo_inc   = (tmo_q == 8'hFF) ? tmo_q : tmo_q + 8'd1;
      drop_sat  = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;

      buf_acc = buf_q;
      if (acc) buf_acc[{cnt_q, 1'b0} +: 2] = atom_data;

      full     = acc && (cnt_q == 4'd14);
      flush_ev = flush_req && cnt_nz;
      // Close on the edge where the idle count would reach the limit.
      tmo_ev   = (TMO != 8'd0) && cnt_nz && !acc && (tmo_inc == TMO);
      dis_ev   = en_q && !trace_enable && cnt_nz;
      close    = full || flush_ev || tmo_ev || dis_ev;

      unique case (1'b1)
         full:     tag = 2'b01;
         flush_ev: tag = 2'b10;
         default:  tag = 2'b11;
      endcase

      // Only a full close includes this cycle's atom.
      wbuf = full ? buf_acc : buf_q;
      wcnt = full ? 4'd15 : cnt_q;

      state_d = state_q;
      buf_d   = buf_q;
      cnt_d   = cnt_q;
      tag_d   = tag_q;
      tmo_d   = tmo_q;
      ov_d    = ov_q && !out.out_ready;
      od_d    = od_q;
      drop_d  = drop_q;
      fd_d    = 1'b0;
      fpend_d = fpend_q;

      unique case (state_q)
         FILL: begin
            if (close) begin
               tmo_d = 8'd0;
               if (slot_free) begin
                  ov_d = 1'b1;
                  od_d = {wcnt, tag, wbuf};
                  fd_d = flush_req;
                  if (acc && !full) begin
                     buf_d = {28'd0, atom_data};
                     cnt_d = 4'd1;
                  end else begin
                     buf_d = 30'd0;
                     cnt_d = 4'd0;
                  end
               end else begin
                  state_d = HOLD;
                  buf_d   = wbuf;
                  cnt_d   = wcnt;
                  tag_d   = tag;
                  fpend_d = flush_req;
                  // A non-full close freezes the buffer, so this atom is lost.
                  if (acc && !full) drop_d = drop_sat;
               end
            end else begin
               buf_d = buf_acc;
               cnt_d = cnt_q + {3'd0, acc};
               fd_d  = flush_req;
               tmo_d = (acc || !cnt_nz) ? 8'd0 : tmo_inc;
            end
         end
         HOLD: begin
            tmo_d   = 8'd0;
            fpend_d = fpend_q || flush_req;
            if (arrive) drop_d = drop_sat;
            if (take) begin
               state_d = FILL;
               ov_d    = 1'b1;
               od_d    = {cnt_q, tag_q, buf_q};
               buf_d   = 30'd0;
               cnt_d   = 4'd0;
               fd_d    = fpend_q || flush_req;
               fpend_d = 1'b0;
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= FILL;
         buf_q   <= 30'd0;
         cnt_q   <= 4'd0;
         tag_q   <= 2'b00;
         tmo_q   <= 8'd0;
         ov_q    <= 1'b0;
         od_q    <= 36'd0;
         drop_q  <= 8'd0;
         fd_q    <= 1'b0;
         stall_q <= 1'b0;
         en_q    <= 1'b0;
         fpend_q <= 1'b0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         cnt_q   <= cnt_d;
         tag_q   <= tag_d;
         tmo_q   <= tmo_d;
         ov_q    <= ov_d;
         od_q    <= od_d;
         drop_q  <= drop_d;
         fd_q    <= fd_d;
         stall_q <= (state_d == HOLD);
         en_q    <= trace_enable;
         fpend_q <= fpend_d;
      end
   end

   assign out.out_valid = ov_q;
   assign out.out_data  = od_q;
   assign dct_buffer    = buf_q;
   assign dct_count     = cnt_q;
   assign stall         = stall_q;
   assign drop_count    = drop_q;
   assign flush_done    = fd_q;

endmodule

// File: tb/tb_nios2_oci_dct_sequencer.sv
// Directed bench for nios2_oci_dct_sequencer with an output scoreboard.
// Expected words are queued as stimulus is driven and checked on handshake.
module tb_nios2_oci_dct_sequencer;

   logic        clk;
   logic        reset;
   logic        trace_enable;
   logic        atom_valid;
   logic [1:0]  atom_data;
   logic        flush_req;
   logic [29:0] dct_buffer;
   logic [3:0]  dct_count;
   logic        stall;
   logic [7:0]  drop_count;
   logic        flush_done;

   nios2_oci_dct_sequencer_if out_if ();

   nios2_oci_dct_sequencer #(.FLUSH_TIMEOUT(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .trace_enable (trace_enable),
      .atom_valid   (atom_valid),
      .atom_data    (atom_data),
      .flush_req    (flush_req),
      .out          (out_if.master),
      .dct_buffer   (dct_buffer),
      .dct_count    (dct_count),
      .stall        (stall),
      .drop_count   (drop_count),
      .flush_done   (flush_done)
   );

   int n_chk;
   int n_fail;
   logic [35:0] exp_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic atom(input logic [1:0] d);
      atom_valid = 1'b1;
      atom_data  = d;
      tick();
      atom_valid = 1'b0;
   endtask

   task automatic chk_all_zero(string tag);
      chk({tag, "_ov"}, 64'(out_if.out_valid), 0);
      chk({tag, "_od"}, 64'(out_if.out_data), 0);
      chk({tag, "_buf"}, 64'(dct_buffer), 0);
      chk({tag, "_cnt"}, 64'(dct_count), 0);
      chk({tag, "_stall"}, 64'(stall), 0);
      chk({tag, "_drop"}, 64'(drop_count), 0);
      chk({tag, "_fd"}, 64'(flush_done), 0);
   endtask

   always @(negedge clk) begin
      if (!reset && out_if.out_valid && out_if.out_ready) begin
         n_chk++;
         assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL sb_unexpected observed=%0h expected=none",
                   out_if.out_data);
         end
         if (exp_q.size() != 0)
            chk("sb_word", 64'(out_if.out_data), 64'(exp_q.pop_front()));
      end
   end

   initial begin
      n_chk = 0;
      n_fail = 0;
      reset = 1'b1;
      trace_enable = 1'b0;
      atom_valid = 1'b0;
      atom_data = 2'b00;
      flush_req = 1'b0;
      out_if.out_ready = 1'b0;
      tick();
      tick();
      chk_all_zero("rst");
      reset = 1'b0;
      trace_enable = 1'b1;
      tick();

      // Full buffer of 01 atoms.
      out_if.out_ready = 1'b1;
      exp_q.push_back({4'hF, 2'b01, 30'h15555555});
      for (int i = 0; i < 8; i++) atom(2'b01);
      chk("fill8_cnt", 64'(dct_count), 8);
      chk("fill8_buf", 64'(dct_buffer), 64'h5555);
      for (int i = 0; i < 7; i++) atom(2'b01);
      chk("full_ov", 64'(out_if.out_valid), 1);
      chk("full_cnt", 64'(dct_count), 0);
      tick();
      chk("full_drain", 64'(out_if.out_valid), 0);

      // Explicit flush of a partial buffer.
      atom(2'b10);
      atom(2'b11);
      atom(2'b00);
      chk("p3_buf", 64'(dct_buffer), 64'h0E);
      exp_q.push_back({4'h3, 2'b10, 30'h0000000E});
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      chk("flush_ov", 64'(out_if.out_valid), 1);
      chk("flush_done", 64'(flush_done), 1);
      chk("flush_cnt", 64'(dct_count), 0);
      tick();
      chk("flush_done_end", 64'(flush_done), 0);
      chk("flush_drain", 64'(out_if.out_valid), 0);

      // Flush with an empty buffer: pulse only, no word.
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      chk("eflush_done", 64'(flush_done), 1);
      chk("eflush_ov", 64'(out_if.out_valid), 0);
      tick();
      chk("eflush_done_end", 64'(flush_done), 0);

      // Idle timeout after two atoms (limit 4).
      atom(2'b01);
      atom(2'b10);
      exp_q.push_back({4'h2, 2'b11, 30'h00000009});
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("tmo_wait", 64'(out_if.out_valid), 0);
      end
      tick();
      chk("tmo_ov", 64'(out_if.out_valid), 1);
      chk("tmo_cnt", 64'(dct_count), 0);
      tick();

      // Trace disable closes the buffer.
      atom(2'b11);
      atom(2'b11);
      atom(2'b11);
      exp_q.push_back({4'h3, 2'b11, 30'h0000003F});
      trace_enable = 1'b0;
      tick();
      chk("dis_ov", 64'(out_if.out_valid), 1);
      trace_enable = 1'b1;
      tick();
      chk("dis_drain", 64'(out_if.out_valid), 0);

      // Backpressure: second full buffer held, then drops.
      out_if.out_ready = 1'b0;
      exp_q.push_back({4'hF, 2'b01, 30'h15555555});
      exp_q.push_back({4'hF, 2'b01, 30'h2AAAAAAA});
      for (int i = 0; i < 15; i++) atom(2'b01);
      for (int i = 0; i < 15; i++) atom(2'b10);
      chk("hold_stall", 64'(stall), 1);
      chk("hold_drop0", 64'(drop_count), 0);
      chk("hold_cnt", 64'(dct_count), 15);
      chk("hold_ov", 64'(out_if.out_valid), 1);
      for (int i = 0; i < 5; i++) atom(2'b11);
      chk("hold_drop5", 64'(drop_count), 5);
      chk("hold_stall2", 64'(stall), 1);
      out_if.out_ready = 1'b1;
      tick();
      chk("rel_stall", 64'(stall), 0);
      chk("rel_ov", 64'(out_if.out_valid), 1);
      chk("rel_cnt", 64'(dct_count), 0);
      tick();
      chk("rel_drain", 64'(out_if.out_valid), 0);

      // Sixteen atoms back to back: the last starts a new buffer.
      exp_q.push_back({4'hF, 2'b01, 30'h3FFFFFFF});
      for (int i = 0; i < 15; i++) atom(2'b11);
      atom(2'b10);
      chk("a16_cnt", 64'(dct_count), 1);
      chk("a16_buf", 64'(dct_buffer), 2);
      chk("a16_drop", 64'(drop_count), 5);
      exp_q.push_back({4'h1, 2'b10, 30'h00000002});
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      tick();
      chk("a16_drain", 64'(out_if.out_valid), 0);

      // Reset mid-operation discards pending word and buffer.
      out_if.out_ready = 1'b0;
      for (int i = 0; i < 15; i++) atom(2'b01);
      for (int i = 0; i < 7; i++) atom(2'b10);
      chk("prerst_cnt", 64'(dct_count), 7);
      chk("prerst_ov", 64'(out_if.out_valid), 1);
      reset = 1'b1;
      #1;
      chk_all_zero("mid_rst");
      tick();
      reset = 1'b0;
      out_if.out_ready = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      chk("post_rst_ov", 64'(out_if.out_valid), 0);
      chk("post_rst_fd", 64'(flush_done), 0);
      chk("sb_empty", 64'(exp_q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
